// File: rtl/pccmd_issue_if.sv
// Stream bundle around the command issuer: instruction in, pccmd out, done feedback in.
// The slave modport is the issuer's view; master is the surrounding fabric's view.
interface pccmd_issue_if #(
    parameter int PCCMD_WIDTH = 32,
    parameter int PCFBK_WIDTH = 8
);
    logic                   s_axis_inst_tvalid;
    logic                   s_axis_inst_tready;
    logic [PCCMD_WIDTH+3:0] s_axis_inst_tdata;

    logic                   m_axis_pccmd_tvalid;
    logic                   m_axis_pccmd_tready;
    logic [PCCMD_WIDTH-1:0] m_axis_pccmd_tdata;

    logic                   s_axis_pcfbk_tvalid;
    logic                   s_axis_pcfbk_tready;
    logic [PCFBK_WIDTH-1:0] s_axis_pcfbk_tdata;

    modport slave (
        input  s_axis_inst_tvalid, s_axis_inst_tdata,
        output s_axis_inst_tready,
        output m_axis_pccmd_tvalid, m_axis_pccmd_tdata,
        input  m_axis_pccmd_tready,
        input  s_axis_pcfbk_tvalid, s_axis_pcfbk_tdata,
        output s_axis_pcfbk_tready
    );

    modport master (
        output s_axis_inst_tvalid, s_axis_inst_tdata,
        input  s_axis_inst_tready,
        input  m_axis_pccmd_tvalid, m_axis_pccmd_tdata,
        output m_axis_pccmd_tready,
        output s_axis_pcfbk_tvalid, s_axis_pcfbk_tdata,
        input  s_axis_pcfbk_tready
    );
endinterface

// File: rtl/pccmd_issue.sv
// Dependency-aware pccmd issuer: holds one command until every unit in its wait
// mask has no outstanding operations, tracking per-unit counts from done pulses.
module pccmd_issue #(
    parameter int PCCMD_WIDTH = 32,
    parameter int PCFBK_WIDTH = 8,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pccmd_issue_if.slave           bus,
    output logic [4*CNT_WIDTH-1:0] outstanding,
    output logic                   busy,
    output logic                   fbk_underflow,
    output logic [31:0]            issued_cnt
);
    // Unit index order everywhere: 0 store, 1 exec, 2 loadx, 3 loady.
    typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                 state, next_state;
    logic [PCCMD_WIDTH-1:0] hold_word;
    logic [3:0]             hold_mask;
    logic [3:0]             hold_unit;
    logic [CNT_WIDTH-1:0]   cnt [4];
    logic [3:0]             cnt_zero, cnt_full, inc, dec, underflow_hit;
    logic                   inst_hs, issue_hs, eligible;
    logic                   unused_fbk_bits;

    function automatic logic [3:0] unit_of(input logic [3:0] low);
        logic [3:0] u;
        u = 4'b0000;
        casez (low[2:0])
            3'b001:  u = low[3] ? 4'b1000 : 4'b0100;
            3'b010:  u = 4'b0100;
            3'b011:  u = 4'b0001;
            3'b1??:  u = 4'b0010;
            default: u = 4'b0000;
        endcase
        return u;
    endfunction

    assign bus.s_axis_inst_tready  = rst_n && (state == IDLE);
    assign bus.m_axis_pccmd_tvalid = (state == ISSUE);
    assign bus.m_axis_pccmd_tdata  = hold_word;
    assign bus.s_axis_pcfbk_tready = 1'b1;

    assign inst_hs  = bus.s_axis_inst_tvalid && bus.s_axis_inst_tready;
    assign issue_hs = (state == ISSUE) && bus.m_axis_pccmd_tready;

    assign unused_fbk_bits = ^bus.s_axis_pcfbk_tdata[PCFBK_WIDTH-1:4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_zero[i]      = (cnt[i] == '0);
            cnt_full[i]      = (cnt[i] == CNT_MAX);
            inc[i]           = issue_hs && hold_unit[i];
            dec[i]           = bus.s_axis_pcfbk_tvalid && bus.s_axis_pcfbk_tdata[i];
            underflow_hit[i] = dec[i] && !inc[i] && cnt_zero[i];
        end
    end

    // Registered counters only: a done pulse unblocks WAIT one cycle later at the earliest.
    assign eligible = ((hold_mask & ~cnt_zero) == 4'b0000) &&
                      ((hold_unit & cnt_full) == 4'b0000);

    assign outstanding = {cnt[3], cnt[2], cnt[1], cnt[0]};
    assign busy        = (state != IDLE) || (cnt_zero != 4'b1111);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (inst_hs)  next_state = WAIT;
            WAIT:    if (eligible) next_state = ISSUE;
            ISSUE:   if (issue_hs) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the holding register is reset because it drives m_axis_pccmd_tdata directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_word <= '0;
            hold_mask <= '0;
            hold_unit <= '0;
        end else if (inst_hs) begin
            hold_word <= bus.s_axis_inst_tdata[PCCMD_WIDTH-1:0];
            hold_mask <= bus.s_axis_inst_tdata[PCCMD_WIDTH+3:PCCMD_WIDTH];
            hold_unit <= unit_of(bus.s_axis_inst_tdata[3:0]);
        end
    end

    // Issue and done on the same unit in one cycle cancel; eligibility prevents overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            fbk_underflow <= 1'b0;
            issued_cnt    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (inc[i] && !dec[i])                  cnt[i] <= cnt[i] + 1'b1;
                else if (dec[i] && !inc[i] && !cnt_zero[i]) cnt[i] <= cnt[i] - 1'b1;
            end
            if (underflow_hit != 4'b0000) fbk_underflow <= 1'b1;
            if (issue_hs)                 issued_cnt    <= issued_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_pccmd_issue.sv
// Directed bench for pccmd_issue: dependency holds, backpressure, counter limits,
// same-cycle cancel, multi-bit done, underflow flag and reset mid-issue.
module tb_pccmd_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] outstanding;
    logic        busy, fbk_underflow;
    logic [31:0] issued_cnt;
    int          checks = 0;
    int          errors = 0;
    int          exp_issued = 0;

    pccmd_issue_if #(.PCCMD_WIDTH(32), .PCFBK_WIDTH(8)) bus ();

    pccmd_issue #(.PCCMD_WIDTH(32), .PCFBK_WIDTH(8), .CNT_WIDTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .outstanding   (outstanding),
        .busy          (busy),
        .fbk_underflow (fbk_underflow),
        .issued_cnt    (issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] word, input logic [3:0] mask);
        check("inst_ready", bus.s_axis_inst_tready, 1'b1);
        bus.s_axis_inst_tvalid = 1'b1;
        bus.s_axis_inst_tdata  = {mask, word};
        step();
        bus.s_axis_inst_tvalid = 1'b0;
    endtask

    // Full issue of an eligible command with m_tready held high: accept, WAIT, ISSUE, handshake.
    task automatic issue_now(input logic [31:0] word, input logic [3:0] mask);
        send(word, mask);
        step();
        check("issue_tvalid", bus.m_axis_pccmd_tvalid, 1'b1);
        check("issue_tdata", bus.m_axis_pccmd_tdata, word);
        step();
        exp_issued++;
        check("issued_cnt", issued_cnt, exp_issued);
    endtask

    task automatic done(input logic [7:0] bits, input int cycles);
        bus.s_axis_pcfbk_tvalid = 1'b1;
        bus.s_axis_pcfbk_tdata  = bits;
        for (int i = 0; i < cycles; i++) step();
        bus.s_axis_pcfbk_tvalid = 1'b0;
        bus.s_axis_pcfbk_tdata  = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.s_axis_inst_tvalid  = 1'b0;
        bus.s_axis_inst_tdata   = '0;
        bus.m_axis_pccmd_tready = 1'b1;
        bus.s_axis_pcfbk_tvalid = 1'b0;
        bus.s_axis_pcfbk_tdata  = 8'h00;
        step();
        step();
        check("rst_tvalid", bus.m_axis_pccmd_tvalid, 1'b0);
        check("rst_outstanding", outstanding, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_issued", issued_cnt, 32'd0);
        check("rst_fbk_ready", bus.s_axis_pcfbk_tready, 1'b1);
        rst_n = 1'b1;
        step();

        // Single exec command, tvalid two cycles after acceptance
        send(32'h1234_5674, 4'b0000);
        check("t1_wait_tvalid", bus.m_axis_pccmd_tvalid, 1'b0);
        check("t1_wait_tready", bus.s_axis_inst_tready, 1'b0);
        step();
        check("t1_tvalid", bus.m_axis_pccmd_tvalid, 1'b1);
        check("t1_tdata", bus.m_axis_pccmd_tdata, 32'h1234_5674);
        check("t1_busy_issue", busy, 1'b1);
        step();
        exp_issued++;
        check("t1_tvalid_drop", bus.m_axis_pccmd_tvalid, 1'b0);
        check("t1_exec_cnt", outstanding, 16'h0010);
        check("t1_issued", issued_cnt, exp_issued);
        check("t1_busy_cnt", busy, 1'b1);
        done(8'h02, 1);
        check("t1_exec_done", outstanding, 16'h0000);
        check("t1_idle_busy", busy, 1'b0);

        // exec waits on loadx; done at T releases tvalid at T+2
        issue_now(32'h0000_0011, 4'b0000);
        check("t2_loadx_cnt", outstanding, 16'h0100);
        send(32'hABCD_0006, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_held", bus.m_axis_pccmd_tvalid, 1'b0);
        end
        done(8'h04, 1);
        check("t2_loadx_done", outstanding, 16'h0000);
        check("t2_not_yet", bus.m_axis_pccmd_tvalid, 1'b0);
        step();
        check("t2_release", bus.m_axis_pccmd_tvalid, 1'b1);
        check("t2_tdata", bus.m_axis_pccmd_tdata, 32'hABCD_0006);
        step();
        exp_issued++;
        check("t2_exec_cnt", outstanding, 16'h0010);
        check("t2_issued", issued_cnt, exp_issued);
        done(8'h02, 1);

        // Backpressure during ISSUE
        bus.m_axis_pccmd_tready = 1'b0;
        send(32'h5555_0003, 4'b0000);
        step();
        for (int i = 0; i < 5; i++) begin
            check("t3_bp_tvalid", bus.m_axis_pccmd_tvalid, 1'b1);
            check("t3_bp_tdata", bus.m_axis_pccmd_tdata, 32'h5555_0003);
            check("t3_bp_inst_ready", bus.s_axis_inst_tready, 1'b0);
            check("t3_bp_cnt", outstanding, 16'h0000);
            step();
        end
        bus.m_axis_pccmd_tready = 1'b1;
        step();
        exp_issued++;
        check("t3_hs_tvalid", bus.m_axis_pccmd_tvalid, 1'b0);
        check("t3_store_cnt", outstanding, 16'h0001);
        check("t3_issued", issued_cnt, exp_issued);
        done(8'h01, 1);

        // Store counter fills to 15; the 16th waits for one done
        for (int i = 0; i < 15; i++) issue_now(32'h0000_0103 + (i << 8), 4'b0000);
        check("t4_store_15", outstanding, 16'h000F);
        send(32'h0000_FF03, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_store_full_held", bus.m_axis_pccmd_tvalid, 1'b0);
        end
        check("t4_store_still_15", outstanding, 16'h000F);
        done(8'h01, 1);
        check("t4_store_14", outstanding, 16'h000E);
        step();
        check("t4_release", bus.m_axis_pccmd_tvalid, 1'b1);
        step();
        exp_issued++;
        check("t4_store_back_15", outstanding, 16'h000F);
        check("t4_issued", issued_cnt, exp_issued);

        // Same-cycle store issue and store done cancel
        done(8'h01, 12);
        check("t5_store_3", outstanding, 16'h0003);
        send(32'h0000_0A03, 4'b0000);
        step();
        check("t5_tvalid", bus.m_axis_pccmd_tvalid, 1'b1);
        done(8'h01, 1);
        exp_issued++;
        check("t5_cancel", outstanding, 16'h0003);
        check("t5_issued", issued_cnt, exp_issued);

        // Multi-bit done with every counter at 1
        done(8'h01, 2);
        issue_now(32'h0000_0004, 4'b0000);
        issue_now(32'h0000_0001, 4'b0000);
        issue_now(32'h0000_0009, 4'b0000);
        check("t5_all_one", outstanding, 16'h1111);
        done(8'h0F, 1);
        check("t5_all_zero", outstanding, 16'h0000);
        check("t5_no_underflow", fbk_underflow, 1'b0);

        // Config commands leave counters alone; mask 1111 acts as a barrier
        issue_now(32'hC0FF_EE00, 4'b1111);
        check("t6_cfg_cnt", outstanding, 16'h0000);
        issue_now(32'h0000_0005, 4'b0000);
        send(32'hC0DE_0000, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_barrier_held", bus.m_axis_pccmd_tvalid, 1'b0);
        end
        done(8'h02, 1);
        check("t6_barrier_not_yet", bus.m_axis_pccmd_tvalid, 1'b0);
        step();
        check("t6_barrier_release", bus.m_axis_pccmd_tvalid, 1'b1);
        step();
        exp_issued++;
        check("t6_cfg_cnt2", outstanding, 16'h0000);
        check("t6_issued", issued_cnt, exp_issued);
        check("t6_busy", busy, 1'b0);

        // Underflow is sticky
        done(8'h08, 1);
        check("t7_underflow", fbk_underflow, 1'b1);
        check("t7_loady_zero", outstanding, 16'h0000);
        step();
        check("t7_underflow_sticky", fbk_underflow, 1'b1);

        // Reset while a command is held in ISSUE
        bus.m_axis_pccmd_tready = 1'b0;
        send(32'h0000_0004, 4'b0000);
        step();
        check("t8_pre_tvalid", bus.m_axis_pccmd_tvalid, 1'b1);
        rst_n = 1'b0;
        step();
        check("t8_rst_tvalid", bus.m_axis_pccmd_tvalid, 1'b0);
        check("t8_rst_tdata", bus.m_axis_pccmd_tdata, 32'h0);
        check("t8_rst_inst_ready", bus.s_axis_inst_tready, 1'b0);
        check("t8_rst_outstanding", outstanding, 16'h0000);
        check("t8_rst_busy", busy, 1'b0);
        check("t8_rst_underflow", fbk_underflow, 1'b0);
        check("t8_rst_issued", issued_cnt, 32'd0);
        check("t8_rst_fbk_ready", bus.s_axis_pcfbk_tready, 1'b1);
        rst_n = 1'b1;
        step();
        check("t8_post_inst_ready", bus.s_axis_inst_tready, 1'b1);
        check("t8_post_tvalid", bus.m_axis_pccmd_tvalid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pccmd_issue.md
Name: pccmd_issue

Overview:
- Dependency-aware command issuer directly upstream of the PC command controller.
- Takes tagged instructions (32-bit pccmd word plus a 4-bit wait mask) from the instruction fetch stream and drives the pccmd AXIS.
- Consumes the controller's pcfbk done pulses to keep per-unit outstanding-operation scoreboards for loadx, loady, exec and store.
- Holds each command until every unit named in its wait mask has drained to zero outstanding operations.

Parameters:
- PCCMD_WIDTH, 32, width of the pccmd word forwarded downstream.
- PCFBK_WIDTH, 8, width of the feedback tdata.
- CNT_WIDTH, 4, width of each outstanding counter; maximum outstanding per unit is 2^CNT_WIDTH-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- s_axis_inst_tvalid  in  1  instruction valid.
- s_axis_inst_tready  out  1  instruction ready.
- s_axis_inst_tdata  in  PCCMD_WIDTH+4  instruction: [PCCMD_WIDTH-1:0] pccmd word; [PCCMD_WIDTH+3:PCCMD_WIDTH] wait mask {loady, loadx, exec, store}.
- m_axis_pccmd_tvalid  out  1  command valid to the controller.
- m_axis_pccmd_tready  in  1  controller ready.
- m_axis_pccmd_tdata  out  PCCMD_WIDTH  command word.
- s_axis_pcfbk_tvalid  in  1  done pulse valid.
- s_axis_pcfbk_tready  out  1  tied 1.
- s_axis_pcfbk_tdata  in  PCFBK_WIDTH  done bits: [0] store, [1] exec, [2] loadx, [3] loady.
- outstanding  out  4*CNT_WIDTH  counters packed {loady, loadx, exec, store}.
- busy  out  1  high when the holding register is full or any counter is nonzero.
- fbk_underflow  out  1  sticky error flag.
- issued_cnt  out  32  count of commands issued, wraps modulo 2^32.

Behaviour:
- Reset is synchronous, active-low, on clk. All outputs reset to 0, except s_axis_pcfbk_tready, which is constant 1. State resets to IDLE and all counters to 0.
- Unit classification uses cmd type = tdata[2:0]:
  - 000 (config): no unit.
  - 001: tdata[3]=0 selects loadx, tdata[3]=1 selects loady.
  - 010 (load fpv): loadx.
  - 011: store.
  - 1xx: exec.
- States:
  - IDLE: s_axis_inst_tready=1. On instruction handshake, latch word and mask into the holding register; go to WAIT.
  - WAIT: s_axis_inst_tready=0. The command is eligible when (a) the registered counter of every masked unit is 0, and (b) the command's own unit counter is below 2^CNT_WIDTH-1, or the command has no unit. When eligible, set m_axis_pccmd_tvalid<=1 and go to ISSUE.
  - ISSUE: m_axis_pccmd_tvalid=1 with tdata stable until handshake. On handshake: increment the unit's counter, increment issued_cnt, drop tvalid, go to IDLE.
- Latency: instruction accepted at cycle N; tvalid asserts at N+2 at the earliest. Maximum throughput is one command per 3 cycles.
- Eligibility uses registered counters only. A done pulse in cycle N can unblock WAIT no earlier than cycle N+1.
- Feedback:
  - Every cycle with s_axis_pcfbk_tvalid=1, each set done bit decrements its counter.
  - Several bits may be set in one beat; each counter updates independently.
- Same-unit issue handshake and done in the same cycle: counter unchanged.
- Done arriving for a counter already at 0: the counter stays 0 and fbk_underflow is set. fbk_underflow clears only on reset.
- Config commands (type 000) never touch counters. A mask of 4'b1111 on any command acts as a full barrier.
- Counters saturate by construction: the eligibility check blocks any issue that would overflow. No wrap is possible.
- Reset mid-ISSUE: tvalid drops the next cycle and the held command is discarded. The controller is reset alongside, so no counts are stale.

Test Plan:
- Single exec command (type 3'b100), mask 0, m_tready=1 → pccmd tvalid at cycle 2 with an identical word. outstanding.exec=1, issued_cnt=1, busy=1. Then pcfbk tdata=8'h02 → exec=0, busy=0.
- Issue loadx (tdata[2:0]=001, [3]=0), then exec with mask 4'b0100 → exec is held in WAIT. pcfbk 8'h04 at cycle T → exec tvalid at T+2 and not before.
- Backpressure: m_tready=0 for 5 cycles during ISSUE → tvalid and tdata stable, s_axis_inst_tready=0, counters unchanged. Counter increments only on the handshake cycle.
- Issue 15 store commands (type 011) with no done → 16th store waits in WAIT. One pcfbk 8'h01 → the 16th issues; store counter returns to 15.
- Same-cycle handshake of store issue and pcfbk 8'h01 with store counter=3 → counter stays 3. Multi-bit pcfbk 8'h0F with all counters =1 → all become 0.
- pcfbk 8'h08 with loady=0 → fbk_underflow=1 and loady stays 0. Flag persists until rst_n=0 for one cycle, then all outputs are 0.
